// File: rtl/hack_mem_sequencer_pkg.sv
// Shared definitions for the Hack memory sequencer: state encoding and
// instruction bit positions used to decide whether an M operand is needed.
package hack_mem_sequencer_pkg;

  localparam int INSTR_C = 15;
  localparam int A_BIT   = 12;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_D,
    READ_A,
    READ_D,
    STEP,
    DMA_A,
    DMA_D
  } state_t;

  // A C-instruction with the a-bit set reads M before it can execute.
  function automatic logic uses_m(input logic [15:0] instr);
    return instr[INSTR_C] & instr[A_BIT];
  endfunction

endpackage

// File: rtl/hack_mem_sequencer_dma_arb.sv
// DMA grant decision taken at each instruction boundary, limited by a burst
// counter so the CPU always gets an instruction after DMA_BURST accesses.
module hack_dma_arb #(
  parameter int DMA_BURST = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic boundary,
  input  logic dma_req,
  output logic take_dma
);

  localparam int CW = $clog2(DMA_BURST + 1);

  logic [CW-1:0] cnt;

  assign take_dma = boundary && dma_req && (cnt < CW'(DMA_BURST));

  // Any boundary that goes to the CPU restarts the burst allowance.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (boundary) begin
      cnt <= take_dma ? cnt + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/hack_mem_sequencer.sv
// Fetch/execute sequencer for the Hack CPU on a single-port unified memory,
// with a DMA requester slotted in between instructions.
module hack_mem_sequencer
  import hack_mem_sequencer_pkg::*;
#(
  parameter int AW        = 15,
  parameter int DW        = 16,
  parameter int DMA_BURST = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] addressM,
  input  logic [DW-1:0] outM,
  input  logic          writeM,
  output logic [DW-1:0] instruction,
  output logic [DW-1:0] inM,
  output logic          cpu_step,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic          dma_we,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_valid,
  output logic [DW-1:0] dma_rdata
);

  state_t        state, next_state;
  logic          take_dma;
  logic          dma_rd;
  logic [DW-1:0] ir_q, inm_q, rdata_q;

  hack_dma_arb #(.DMA_BURST(DMA_BURST)) u_arb (
    .clock    (clock),
    .reset    (reset),
    .boundary (state == IDLE),
    .dma_req  (dma_req),
    .take_dma (take_dma)
  );

  // dma_rd remembers the direction of the grant so DMA_D knows whether to return data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      ir_q    <= '0;
      inm_q   <= '0;
      rdata_q <= '0;
      dma_rd  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == FETCH_D) ir_q <= mem_rdata;
      if (state == READ_D) inm_q <= mem_rdata;
      if (state == DMA_A) dma_rd <= ~dma_we;
      if (state == DMA_D && dma_rd) rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    next_state = state;
    mem_addr   = pc;
    mem_wdata  = outM;
    mem_we     = 1'b0;
    cpu_step   = 1'b0;
    dma_gnt    = 1'b0;
    dma_valid  = 1'b0;
    case (state)
      IDLE:    next_state = take_dma ? DMA_A : FETCH_A;
      FETCH_A: next_state = FETCH_D;
      FETCH_D: next_state = uses_m(mem_rdata[15:0]) ? READ_A : STEP;
      READ_A: begin
        mem_addr   = addressM;
        next_state = READ_D;
      end
      READ_D: begin
        mem_addr   = addressM;
        next_state = STEP;
      end
      STEP: begin
        cpu_step = 1'b1;
        if (writeM) begin
          mem_we   = 1'b1;
          mem_addr = addressM;
        end
        next_state = IDLE;
      end
      DMA_A: begin
        dma_gnt    = 1'b1;
        mem_addr   = dma_addr;
        mem_wdata  = dma_wdata;
        mem_we     = dma_we;
        next_state = DMA_D;
      end
      DMA_D: begin
        dma_valid  = dma_rd;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Reset abandons whatever access is in flight.
    if (reset) begin
      next_state = IDLE;
      mem_we     = 1'b0;
      cpu_step   = 1'b0;
      dma_gnt    = 1'b0;
      dma_valid  = 1'b0;
    end
  end

  assign instruction = ir_q;
  assign inM         = inm_q;
  assign dma_rdata   = dma_valid ? mem_rdata : rdata_q;

endmodule
